wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter onto one shared slave.
// Round-robin on ties, no preemption, and a per-strobe timeout that ends a
// stalled access with an error.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_dat_ms,
  output logic [31:0] m0_dat_sm,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_dat_ms,
  output logic [31:0] m1_dat_sm,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [3:0]  s_sel,
  output logic [31:0] s_dat_ms,
  input  logic [31:0] s_dat_sm,
  input  logic        s_ack,
  output logic [1:0]  gnt
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [CW-1:0] r_cnt;

  logic          w_g0;
  logic          w_g1;
  logic          w_any;
  logic          w_cyc;
  logic          w_stb;
  logic          w_timeout;

  assign w_g0  = (r_state == GNT0);
  assign w_g1  = (r_state == GNT1);
  assign w_any = w_g0 | w_g1;

  // Request path from whichever master holds the grant; all zero when idle.
  always_comb begin
    w_cyc    = 1'b0;
    w_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = 32'd0;
    s_sel    = 4'd0;
    s_dat_ms = 32'd0;
    if (w_g0) begin
      w_cyc    = m0_cyc;
      w_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_sel    = m0_sel;
      s_dat_ms = m0_dat_ms;
    end else if (w_g1) begin
      w_cyc    = m1_cyc;
      w_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_sel    = m1_sel;
      s_dat_ms = m1_dat_ms;
    end
  end

  // Timeout fires on the last allowed wait cycle unless the slave acks then.
  assign w_timeout = w_any & w_stb & ~s_ack & (r_cnt == CW'(TIMEOUT - 1));

  assign s_cyc = w_cyc;
  assign s_stb = w_stb & ~w_timeout;

  assign m0_ack    = w_g0 & s_ack & m0_stb;
  assign m1_ack    = w_g1 & s_ack & m1_stb;
  assign m0_err    = w_g0 & w_timeout;
  assign m1_err    = w_g1 & w_timeout;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  assign gnt = {w_g1, w_g0};

  // Grant FSM with round-robin pointer; a grant is held for the whole cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc && m1_cyc) r_state <= r_last ? GNT0 : GNT1;
          else if (m0_cyc)      r_state <= GNT0;
          else if (m1_cyc)      r_state <= GNT1;
        end
        GNT0: begin
          if (!m0_cyc) begin
            r_last  <= 1'b0;
            r_state <= m1_cyc ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            r_last  <= 1'b1;
            r_state <= m0_cyc ? GNT0 : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Wait counter for the granted strobe; restarts on ack, timeout or no strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_any || !w_stb || s_ack || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with TIMEOUT = 16.
module tb_wb_arbiter2;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [1:0]  gnt;

  int total;
  int bad;

  wb_arbiter2 #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_dat_sm(m0_dat_sm),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_dat_sm(m1_dat_sm),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm),
    .s_ack(s_ack), .gnt(gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_sel = 0; m0_dat_ms = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_sel = 0; m1_dat_ms = 0;
    s_dat_sm = 0;
    s_ack = 1'b1;

    // Reset state, with a stray slave ack that must be ignored
    #3;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_s_stb", 32'(s_stb), 32'd0);
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    tick();
    tick();
    s_ack = 1'b0;
    rst = 1'b1;

    // Simultaneous request after reset: m0 wins the first tie
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h10; m0_sel = 4'hf;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h20; m1_sel = 4'hf;
    #1;
    chk("lat_gnt", 32'(gnt), 32'd0);
    chk("lat_s_cyc", 32'(s_cyc), 32'd0);
    tick();
    chk("tie_gnt", 32'(gnt), 32'd1);
    chk("tie_s_adr", s_adr, 32'h10);
    chk("tie_s_stb", 32'(s_stb), 32'd1);
    chk("tie_m0_ack_wait", 32'(m0_ack), 32'd0);
    s_ack = 1; s_dat_sm = 32'hcafef00d;
    #1;
    chk("rd_m0_ack", 32'(m0_ack), 32'd1);
    chk("rd_m1_ack", 32'(m1_ack), 32'd0);
    chk("rd_m0_err", 32'(m0_err), 32'd0);
    chk("rd_m0_dat", m0_dat_sm, 32'hcafef00d);

    // m0 releases while m1 waits: direct handover, no idle cycle
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    chk("rel_gnt_hold", 32'(gnt), 32'd1);
    tick();
    chk("hand_gnt", 32'(gnt), 32'd2);
    chk("hand_s_adr", s_adr, 32'h20);
    s_ack = 1;
    #1;
    chk("hand_m1_ack", 32'(m1_ack), 32'd1);
    chk("hand_m0_ack", 32'(m0_ack), 32'd0);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick();
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_s_cyc", 32'(s_cyc), 32'd0);
    chk("idle_s_adr", s_adr, 32'd0);
    s_ack = 1;
    #1;
    chk("idle_ack_m0", 32'(m0_ack), 32'd0);
    chk("idle_ack_m1", 32'(m1_ack), 32'd0);
    s_ack = 0;

    // Both again after idle: m1 went last, so m0 is granted
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("rr_gnt", 32'(gnt), 32'd1);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("rr2_gnt", 32'(gnt), 32'd2);

    // m1 burst of three writes while m0 keeps requesting
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    m1_we = 1; m1_sel = 4'hf;
    for (int i = 0; i < 3; i++) begin
      m1_adr = 32'(i * 4);
      m1_dat_ms = 32'h100 + 32'(i);
      s_ack = 1;
      #1;
      chk("burst_gnt", 32'(gnt), 32'd2);
      chk("burst_s_adr", s_adr, 32'(i * 4));
      chk("burst_s_dat", s_dat_ms, 32'h100 + 32'(i));
      chk("burst_s_we", 32'(s_we), 32'd1);
      chk("burst_m1_ack", 32'(m1_ack), 32'd1);
      chk("burst_m0_ack", 32'(m0_ack), 32'd0);
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1;
    chk("burst_end_hold", 32'(gnt), 32'd2);
    tick();
    chk("burst_next_gnt", 32'(gnt), 32'd1);
    chk("burst_next_adr", s_adr, 32'h10);

    // m0 strobe never acked: error on the 16th waiting cycle
    for (int k = 0; k < 15; k++) begin
      chk("to_wait_err", 32'(m0_err), 32'd0);
      chk("to_wait_stb", 32'(s_stb), 32'd1);
      tick();
    end
    chk("to_err", 32'(m0_err), 32'd1);
    chk("to_s_stb", 32'(s_stb), 32'd0);
    chk("to_s_cyc", 32'(s_cyc), 32'd1);
    chk("to_m0_ack", 32'(m0_ack), 32'd0);
    chk("to_m1_err", 32'(m1_err), 32'd0);
    tick();
    chk("to_after_err", 32'(m0_err), 32'd0);
    chk("to_after_gnt", 32'(gnt), 32'd1);

    // Ack landing on the timeout cycle wins and restarts the count
    repeat (15) tick();
    s_ack = 1;
    #1;
    chk("tie_to_ack", 32'(m0_ack), 32'd1);
    chk("tie_to_err", 32'(m0_err), 32'd0);
    chk("tie_to_stb", 32'(s_stb), 32'd1);
    tick();
    s_ack = 0;
    repeat (14) tick();
    chk("clr_err_14", 32'(m0_err), 32'd0);
    tick();
    chk("clr_err_15", 32'(m0_err), 32'd1);
    tick();

    // Asynchronous reset in the middle of a granted strobe
    #2;
    rst = 0;
    s_ack = 1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_s_cyc", 32'(s_cyc), 32'd0);
    chk("arst_m0_ack", 32'(m0_ack), 32'd0);
    chk("arst_m0_err", 32'(m0_err), 32'd0);
    s_ack = 0;
    m0_cyc = 0; m0_stb = 0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h44;
    #1;
    rst = 1;
    #1;
    chk("arst_rel_gnt", 32'(gnt), 32'd0);
    tick();
    chk("arst_m1_gnt", 32'(gnt), 32'd2);
    chk("arst_m1_adr", s_adr, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
